// File: rtl/alu.sv
// 32-bit MIPS-style ALU with registered result and Zero/Overflow flags.
// Optional shifter ops (SLL/SRL/SRA) are enabled by defining ALU_SHIFT_EN.
module alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] scrA,
  input  logic [31:0] scrB,
  input  logic [3:0]  ALUControl,
  output logic [31:0] ALUResult,
  output logic        Zero,
  output logic        Overflow
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1100;
`ifdef ALU_SHIFT_EN
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1001;
`endif

  logic [31:0] sum;
  logic [31:0] diff;
  logic        add_ovf;
  logic        sub_ovf;
  logic [31:0] res_next;
  logic        ovf_next;

  assign sum  = scrA + scrB;
  assign diff = scrA - scrB;

  assign add_ovf = (scrA[31] == scrB[31]) &&
                   (sum[31] != scrA[31]);
  assign sub_ovf = (scrA[31] != scrB[31]) &&
                   (diff[31] != scrA[31]);

  always_comb begin
    res_next = 32'd0;
    ovf_next = 1'b0;
    case (ALUControl)
      OP_AND:  res_next = scrA & scrB;
      OP_OR:   res_next = scrA | scrB;
      OP_ADD: begin
        res_next = sum;
        ovf_next = add_ovf;
      end
      OP_XOR:  res_next = scrA ^ scrB;
      OP_SUB: begin
        res_next = diff;
        ovf_next = sub_ovf;
      end
      // true signed compare, immune to SUB overflow
      OP_SLT:  res_next = {31'd0, $signed(scrA) < $signed(scrB)};
      OP_SLTU: res_next = {31'd0, scrA < scrB};
      OP_NOR:  res_next = ~(scrA | scrB);
`ifdef ALU_SHIFT_EN
      OP_SLL:  res_next = scrA << scrB[4:0];
      OP_SRL:  res_next = scrA >> scrB[4:0];
      OP_SRA:  res_next = $unsigned($signed(scrA) >>> scrB[4:0]);
`endif
      default: begin
        res_next = 32'd0;
        ovf_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ALUResult <= 32'd0;
      Zero      <= 1'b1;
      Overflow  <= 1'b0;
    end else begin
      ALUResult <= res_next;
      Zero      <= (res_next == 32'd0);
      Overflow  <= ovf_next;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu.
// Works in both builds; shift expectations follow ALU_SHIFT_EN.
module tb_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] scrA = 32'd0;
  logic [31:0] scrB = 32'd0;
  logic [3:0]  ALUControl = 4'd0;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        Overflow;

  int total = 0;
  int passed = 0;

  alu dut (
    .clk(clk),
    .reset(reset),
    .scrA(scrA),
    .scrB(scrB),
    .ALUControl(ALUControl),
    .ALUResult(ALUResult),
    .Zero(Zero),
    .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] AS_A [6] = '{3, 3, 26, 26, 10, 10};
  localparam logic [31:0] AS_B [6] = '{2, 2, 15, 15, 10, 10};
  localparam logic [3:0]  AS_OP[6] = '{2, 6, 2, 6, 2, 6};
  localparam logic [31:0] AS_R [6] = '{5, 1, 41, 11, 20, 0};
  localparam logic        AS_Z [6] = '{0, 0, 0, 0, 0, 1};

  localparam logic [31:0] OV_A [3] =
    '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
  localparam logic [3:0]  OV_OP[3] = '{2, 6, 2};
  localparam logic [31:0] OV_R [3] =
    '{32'h80000000, 32'h7FFFFFFF, 32'h0};
  localparam logic        OV_Z [3] = '{0, 0, 1};
  localparam logic        OV_V [3] = '{1, 1, 0};

  localparam logic [3:0]  LG_OP[6] = '{0, 1, 3, 12, 7, 8};
  localparam logic [31:0] LG_R [6] = '{
    32'h00F000F0, 32'hFFF0FFF0, 32'hFF00FF00,
    32'h000F000F, 32'h1, 32'h0};

  localparam logic [3:0]  SH_OP[4] = '{4, 5, 9, 15};
`ifdef ALU_SHIFT_EN
  localparam logic [31:0] SH_R [4] =
    '{32'h10, 32'h08000000, 32'hF8000000, 32'h0};
`else
  localparam logic [31:0] SH_R [4] = '{0, 0, 0, 0};
`endif

  task automatic apply(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op);
    scrA = a;
    scrB = b;
    ALUControl = op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (ALUResult !== 32'd0 || Zero !== 1'b1 || Overflow !== 1'b0)
      $display("FAIL reset_init got r=%h z=%b v=%b want r=0 z=1 v=0",
               ALUResult, Zero, Overflow);
    else passed++;
    #2 reset = 1'b0;
    apply(32'h7FFFFFFF, 32'h1, 4'b0010);
    total++;
    if (ALUResult !== 32'h80000000 || Overflow !== 1'b1)
      $display("FAIL pre_reset got r=%h v=%b want r=80000000 v=1",
               ALUResult, Overflow);
    else passed++;
    #2 reset = 1'b1;
    #1;
    total++;
    if (ALUResult !== 32'd0 || Zero !== 1'b1 || Overflow !== 1'b0)
      $display("FAIL async_reset got r=%h z=%b v=%b want r=0 z=1 v=0",
               ALUResult, Zero, Overflow);
    else passed++;
    apply(32'd3, 32'd2, 4'b0010);
    total++;
    if (ALUResult !== 32'd0 || Zero !== 1'b1 || Overflow !== 1'b0)
      $display("FAIL reset_hold got r=%h z=%b v=%b want r=0 z=1 v=0",
               ALUResult, Zero, Overflow);
    else passed++;
    #2 reset = 1'b0;
  endtask

  task automatic test_add_sub();
    for (int i = 0; i < 6; i++) begin
      apply(AS_A[i], AS_B[i], AS_OP[i]);
      total++;
      if (ALUResult !== AS_R[i] || Zero !== AS_Z[i] || Overflow !== 1'b0)
        $display("FAIL add_sub[%0d] got r=%h z=%b v=%b want r=%h z=%b v=0",
                 i, ALUResult, Zero, Overflow, AS_R[i], AS_Z[i]);
      else passed++;
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      apply(OV_A[i], 32'd1, OV_OP[i]);
      total++;
      if (ALUResult !== OV_R[i] || Zero !== OV_Z[i] ||
          Overflow !== OV_V[i])
        $display("FAIL ovf[%0d] got r=%h z=%b v=%b want r=%h z=%b v=%b",
                 i, ALUResult, Zero, Overflow, OV_R[i], OV_Z[i], OV_V[i]);
      else passed++;
    end
  endtask

  task automatic test_logic();
    for (int i = 0; i < 6; i++) begin
      apply(32'hF0F0F0F0, 32'h0FF00FF0, LG_OP[i]);
      total++;
      if (ALUResult !== LG_R[i] || Overflow !== 1'b0)
        $display("FAIL logic[%0d] got r=%h v=%b want r=%h v=0",
                 i, ALUResult, Overflow, LG_R[i]);
      else passed++;
    end
    apply(32'h80000000, 32'h1, 4'b0111);
    total++;
    if (ALUResult !== 32'd1)
      $display("FAIL slt_min got %h want 00000001", ALUResult);
    else passed++;
  endtask

  task automatic test_shift_undef();
    for (int i = 0; i < 4; i++) begin
      apply(32'h80000001, 32'd4, SH_OP[i]);
      total++;
      if (ALUResult !== SH_R[i] || Zero !== (SH_R[i] == 32'd0) ||
          Overflow !== 1'b0)
        $display("FAIL shift[%0d] got r=%h z=%b v=%b want r=%h",
                 i, ALUResult, Zero, Overflow, SH_R[i]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    scrA = 32'd5; scrB = 32'd7; ALUControl = 4'b0010;
    @(posedge clk);
    #1;
    ALUControl = 4'b0110;
    total++;
    if (ALUResult !== 32'd12)
      $display("FAIL b2b_add got %h want 0000000c", ALUResult);
    else passed++;
    @(posedge clk);
    #1;
    ALUControl = 4'b0111;
    total++;
    if (ALUResult !== 32'hFFFFFFFE)
      $display("FAIL b2b_sub got %h want fffffffe", ALUResult);
    else passed++;
    @(posedge clk);
    #1;
    scrA = 32'd9;
    ALUControl = 4'b0010;
    total++;
    if (ALUResult !== 32'd1)
      $display("FAIL b2b_slt got %h want 00000001", ALUResult);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (ALUResult !== 32'd16)
      $display("FAIL b2b_add2 got %h want 00000010", ALUResult);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_overflow();
    test_logic();
    test_shift_undef();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
